// File: rtl/exe_alu_mul.sv
// Execute-stage ALU with two-cycle multiply sequencing.
// Owns the NZCV status register fed back to the ID stage.
module exe_alu_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             status_update,
  input  logic             freeze,
  output logic [WIDTH-1:0] alu_result,
  output logic [3:0]       status_out,
  output logic             mul_pending,
  output logic             mul_err
);

  localparam int H = WIDTH / 2;
  localparam int M = WIDTH - 1;

  localparam logic [3:0] C_MOV  = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_ADC  = 4'b0011;
  localparam logic [3:0] C_SUB  = 4'b0100;
  localparam logic [3:0] C_SBC  = 4'b0101;
  localparam logic [3:0] C_AND  = 4'b0110;
  localparam logic [3:0] C_ORR  = 4'b0111;
  localparam logic [3:0] C_EOR  = 4'b1000;
  localparam logic [3:0] C_MVN  = 4'b1001;
  localparam logic [3:0] C_MUL1 = 4'b1100;
  localparam logic [3:0] C_MUL2 = 4'b1101;

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] op1;
  logic [H-1:0]     op2_hi;
  logic [3:0]       status;
  logic             pending;
  logic             err;

  logic             c_in;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             cout;
  logic             ovf;
  logic             arith;
  logic             logic_op;

  logic [WIDTH-1:0] lo_ext;
  logic [WIDTH-1:0] hi_ext;
  logic [WIDTH-1:0] partial;
  logic [WIDTH-1:0] hi_prod;
  logic [WIDTH-1:0] product;

  assign c_in    = status[1];
  assign lo_ext  = {{H{1'b0}}, val2[H-1:0]};
  assign hi_ext  = {{H{1'b0}}, op2_hi};
  assign partial = val1 * lo_ext;
  assign hi_prod = op1 * hi_ext;
  assign product = acc + (hi_prod << H);

  always_comb begin
    sum      = '0;
    res      = '0;
    cout     = 1'b0;
    ovf      = 1'b0;
    arith    = 1'b0;
    logic_op = 1'b0;
    unique case (exe_cmd)
      C_MOV: begin res = val2; logic_op = 1'b1; end
      C_MVN: begin res = ~val2; logic_op = 1'b1; end
      C_AND: begin res = val1 & val2; logic_op = 1'b1; end
      C_ORR: begin res = val1 | val2; logic_op = 1'b1; end
      C_EOR: begin res = val1 ^ val2; logic_op = 1'b1; end
      C_ADD, C_ADC: begin
        sum = {1'b0, val1} + {1'b0, val2}
            + {{WIDTH{1'b0}}, (exe_cmd == C_ADC) & c_in};
        res   = sum[M:0];
        cout  = sum[WIDTH];
        ovf   = (val1[M] == val2[M]) & (res[M] != val1[M]);
        arith = 1'b1;
      end
      C_SUB, C_SBC: begin
        sum = {1'b0, val1} - {1'b0, val2}
            - {{WIDTH{1'b0}}, (exe_cmd == C_SBC) & ~c_in};
        res   = sum[M:0];
        cout  = ~sum[WIDTH];
        ovf   = (val1[M] != val2[M]) & (res[M] != val1[M]);
        arith = 1'b1;
      end
      C_MUL1: res = partial;
      C_MUL2: res = pending ? product : '0;
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      op1     <= '0;
      op2_hi  <= '0;
      status  <= '0;
      pending <= 1'b0;
      err     <= 1'b0;
    end else if (!freeze) begin
      err <= 1'b0;
      if (exe_cmd == C_MUL1) begin
        op1     <= val1;
        op2_hi  <= val2[M:H];
        acc     <= partial;
        pending <= 1'b1;
      end else if (exe_cmd == C_MUL2) begin
        if (pending) begin
          pending <= 1'b0;
          if (status_update)
            status[3:2] <= {res[M], res == '0};
        end else begin
          err <= 1'b1;
        end
      end else begin
        // any other command drops an in-flight multiply
        if (pending) begin
          pending <= 1'b0;
          err     <= 1'b1;
        end
        if (status_update && arith)
          status <= {res[M], res == '0, cout, ovf};
        else if (status_update && logic_op)
          status[3:2] <= {res[M], res == '0};
      end
    end
  end

  assign alu_result  = res;
  assign status_out  = status;
  assign mul_pending = pending;
  assign mul_err     = err;

endmodule
